// File: rtl/bus_pkg.sv
// Shared types and constants for the SRAM-style bus arbiter.
package bus_pkg;

  localparam int WMASK_W = 4;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/arb_prio_streak.sv
// Fixed-priority arbiter (store > load > fetch) with an anti-starvation
// streak counter that hands the channel to a waiting fetch after
// MAX_D_STREAK consecutive data grants.
module arb_prio_streak #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic idle,
  input  logic i_rd_en,
  input  logic d_rd_en,
  input  logic d_wr_en,
  output logic grant_i,
  output logic grant_d
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  logic [3:0] streak;
  logic       fetch_override;

  assign fetch_override = i_rd_en && (streak == STREAK_MAX);

  // Grant decision, only meaningful while the FSM sits in IDLE.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (idle) begin
      if (fetch_override)          grant_i = 1'b1;
      else if (d_wr_en || d_rd_en) grant_d = 1'b1;
      else if (i_rd_en)            grant_i = 1'b1;
    end
  end

  // Count consecutive data grants while a fetch is waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      streak <= '0;
    end else if (grant_i || (idle && !i_rd_en)) begin
      streak <= '0;
    end else if (grant_d && i_rd_en && (streak != STREAK_MAX)) begin
      // NOTE: non-blocking for all state so every flop samples pre-edge values.
      streak <= streak + 4'd1;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one single-port memory channel between the instruction fetch port
// and the data load/store port; one transaction outstanding at a time.
module sram_bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_rd_en,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic               i_rd_ready,
  output logic               i_rd_valid,
  output logic [DATA_W-1:0]  i_rd_data,
  input  logic               i_cancel_rd,
  input  logic               d_rd_en,
  input  logic [ADDR_W-1:0]  d_rd_addr,
  output logic               d_rd_ready,
  output logic               d_rd_valid,
  output logic [DATA_W-1:0]  d_rd_data,
  input  logic               d_wr_en,
  input  logic [ADDR_W-1:0]  d_wr_addr,
  input  logic [DATA_W-1:0]  d_wr_data,
  input  logic [WMASK_W-1:0] d_wr_mask,
  output logic               d_wr_busy,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [WMASK_W-1:0] mem_wmask,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [DATA_W-1:0]  mem_rdata
);

  state_t              state;
  owner_t              owner;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [WMASK_W-1:0]  mask_q;
  logic                cancel_flag;

  logic idle;
  logic grant_i;
  logic grant_d;
  logic resp_fire;
  logic fetch_cancel;

  // Gating with reset keeps ready pulses and responses silent during reset.
  assign idle      = (state == IDLE) && !reset;
  assign resp_fire = (state == RESP) && mem_rvalid && !reset;

  arb_prio_streak #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_arb (
    .clock   (clock),
    .reset   (reset),
    .idle    (idle),
    .i_rd_en (i_rd_en),
    .d_rd_en (d_rd_en),
    .d_wr_en (d_wr_en),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  // A store takes precedence over a load inside grant_d.
  assign i_rd_ready = grant_i;
  assign d_rd_ready = grant_d && !d_wr_en;
  assign d_wr_busy  = d_wr_en && !grant_d;

  assign mem_req   = (state == REQ);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = mask_q;

  // Cancel counts for a fetch being accepted now or already in flight.
  assign fetch_cancel = i_cancel_rd &&
                        (grant_i || ((state != IDLE) && (owner == OWN_I)));

  // Zero-cycle pass-through of the read response to its owner.
  assign i_rd_valid = resp_fire && (owner == OWN_I) && !cancel_flag && !i_cancel_rd;
  assign d_rd_valid = resp_fire && (owner == OWN_D);
  assign i_rd_data  = i_rd_valid ? mem_rdata : '0;
  assign d_rd_data  = d_rd_valid ? mem_rdata : '0;

  // Transaction FSM and request latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_I;
      we_q        <= 1'b0;
      // NOTE: datapath latches are reset too so the bus reads 0 out of reset.
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      cancel_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cancel_flag <= 1'b0;
          if (grant_i) begin
            state       <= REQ;
            owner       <= OWN_I;
            we_q        <= 1'b0;
            addr_q      <= i_rd_addr;
            wdata_q     <= '0;
            mask_q      <= '0;
            cancel_flag <= i_cancel_rd;
          end else if (grant_d) begin
            state   <= REQ;
            owner   <= OWN_D;
            we_q    <= d_wr_en;
            addr_q  <= d_wr_en ? d_wr_addr : d_rd_addr;
            wdata_q <= d_wr_en ? d_wr_data : '0;
            mask_q  <= d_wr_en ? d_wr_mask : '0;
          end
        end
        REQ: begin
          if (fetch_cancel) cancel_flag <= 1'b1;
          if (mem_gnt) state <= we_q ? IDLE : RESP;
        end
        RESP: begin
          if (fetch_cancel) cancel_flag <= 1'b1;
          if (mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with hand-computed expectations.
module tb_sram_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_rd_en, i_cancel_rd, d_rd_en, d_wr_en;
  logic [31:0] i_rd_addr, d_rd_addr, d_wr_addr, d_wr_data;
  logic [3:0]  d_wr_mask;
  logic        i_rd_ready, i_rd_valid, d_rd_ready, d_rd_valid, d_wr_busy;
  logic [31:0] i_rd_data, d_rd_data;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int errors = 0;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_rd_en     (i_rd_en),
    .i_rd_addr   (i_rd_addr),
    .i_rd_ready  (i_rd_ready),
    .i_rd_valid  (i_rd_valid),
    .i_rd_data   (i_rd_data),
    .i_cancel_rd (i_cancel_rd),
    .d_rd_en     (d_rd_en),
    .d_rd_addr   (d_rd_addr),
    .d_rd_ready  (d_rd_ready),
    .d_rd_valid  (d_rd_valid),
    .d_rd_data   (d_rd_data),
    .d_wr_en     (d_wr_en),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .d_wr_mask   (d_wr_mask),
    .d_wr_busy   (d_wr_busy),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wmask   (mem_wmask),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks follow a settle.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // From REQ: grant now, return read data on the following cycle.
  task automatic mem_serve(input logic [31:0] data);
    mem_gnt = 1'b1;
    #1;
    cyc();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    #1;
  endtask

  task automatic mem_done();
    cyc();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    i_rd_en = 0; i_cancel_rd = 0; d_rd_en = 0; d_wr_en = 0;
    i_rd_addr = 0; d_rd_addr = 0; d_wr_addr = 0; d_wr_data = 0; d_wr_mask = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    cyc(); cyc();

    // Reset state: requests during reset are not accepted.
    i_rd_en = 1'b1;
    #1;
    check("rst_i_ready", i_rd_ready, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    i_rd_en = 1'b0;
    cyc();
    reset = 1'b0;
    #1;

    // Fetch only.
    i_rd_en = 1'b1; i_rd_addr = 32'h1C00_0000;
    #1;
    check("f_i_ready", i_rd_ready, 1);
    check("f_d_ready", d_rd_ready, 0);
    cyc();
    i_rd_en = 1'b0;
    #1;
    check("f_req", mem_req, 1);
    check("f_we", mem_we, 0);
    check("f_addr", mem_addr, 32'h1C00_0000);
    mem_serve(32'h0280_0C00);
    check("f_valid", i_rd_valid, 1);
    check("f_data", i_rd_data, 32'h0280_0C00);
    check("f_d_valid", d_rd_valid, 0);
    check("f_d_data", d_rd_data, 0);
    mem_done();
    check("f_valid_off", i_rd_valid, 0);
    check("f_idle_req", mem_req, 0);

    // Simultaneous store and load: store first.
    d_wr_en = 1; d_wr_addr = 32'h100; d_wr_data = 32'hDEAD_BEEF; d_wr_mask = 4'hF;
    d_rd_en = 1; d_rd_addr = 32'h104;
    #1;
    check("sl_busy_accept", d_wr_busy, 0);
    check("sl_rd_ready_wait", d_rd_ready, 0);
    cyc();
    d_wr_en = 0;
    #1;
    check("sl_req", mem_req, 1);
    check("sl_we", mem_we, 1);
    check("sl_addr", mem_addr, 32'h100);
    check("sl_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("sl_mask", mem_wmask, 4'hF);
    check("sl_rd_ready_req", d_rd_ready, 0);
    mem_gnt = 1;
    #1;
    cyc();
    mem_gnt = 0;
    #1;
    check("sl_idle_req", mem_req, 0);
    check("sl_rd_ready", d_rd_ready, 1);
    cyc();
    d_rd_en = 0;
    #1;
    check("sl_ld_we", mem_we, 0);
    check("sl_ld_addr", mem_addr, 32'h104);
    mem_serve(32'h1234_5678);
    check("sl_d_valid", d_rd_valid, 1);
    check("sl_d_data", d_rd_data, 32'h1234_5678);
    check("sl_i_valid", i_rd_valid, 0);
    mem_done();

    // Starvation: fetch waits behind exactly four data grants.
    i_rd_en = 1; i_rd_addr = 32'h1C00_0040;
    d_rd_en = 1; d_rd_addr = 32'h200;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("st_d_ready%0d", k), d_rd_ready, 1);
      check($sformatf("st_i_wait%0d", k), i_rd_ready, 0);
      cyc();
      mem_serve(32'hA000_0000 + k);
      mem_done();
    end
    check("st_i_ready", i_rd_ready, 1);
    check("st_d_held", d_rd_ready, 0);
    cyc();
    mem_serve(32'h0000_0013);
    check("st_i_valid", i_rd_valid, 1);
    mem_done();
    // Streak was cleared by the fetch grant, so data wins again.
    check("st_d_again", d_rd_ready, 1);
    check("st_i_again", i_rd_ready, 0);
    cyc();
    i_rd_en = 0; d_rd_en = 0;
    mem_serve(32'h5);
    mem_done();

    // Cancel during RESP.
    i_rd_en = 1; i_rd_addr = 32'h1C00_0080;
    #1;
    check("c_ready", i_rd_ready, 1);
    cyc();
    i_rd_en = 0;
    mem_gnt = 1;
    #1;
    cyc();
    mem_gnt = 0; i_cancel_rd = 1;
    cyc();
    i_cancel_rd = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    check("c_no_valid", i_rd_valid, 0);
    check("c_no_data", i_rd_data, 0);
    mem_done();
    i_rd_addr = 32'h1C00_0084; i_rd_en = 1;
    #1;
    check("c_idle_ready", i_rd_ready, 1);
    cyc();
    i_rd_en = 0;
    mem_serve(32'h0000_0777);
    check("c_next_valid", i_rd_valid, 1);
    check("c_next_data", i_rd_data, 32'h0000_0777);
    mem_done();

    // Stall: store held 5 cycles without grant; a second store waits busy.
    d_wr_en = 1; d_wr_addr = 32'h200; d_wr_data = 32'hCAFE_F00D; d_wr_mask = 4'h5;
    #1;
    check("sv_busy0", d_wr_busy, 0);
    cyc();
    d_wr_addr = 32'h300; d_wr_data = 32'h0BAD_CAFE; d_wr_mask = 4'hA;
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("sv_req%0d", k), mem_req, 1);
      check($sformatf("sv_addr%0d", k), mem_addr, 32'h200);
      check($sformatf("sv_wdata%0d", k), mem_wdata, 32'hCAFE_F00D);
      check($sformatf("sv_mask%0d", k), mem_wmask, 4'h5);
      check($sformatf("sv_busy%0d", k), d_wr_busy, 1);
      cyc();
    end
    mem_gnt = 1;
    #1;
    cyc();
    mem_gnt = 0;
    #1;
    check("sv_idle_req", mem_req, 0);
    check("sv_busy_accept2", d_wr_busy, 0);
    cyc();
    d_wr_en = 0;
    #1;
    check("sv2_addr", mem_addr, 32'h300);
    check("sv2_mask", mem_wmask, 4'hA);
    mem_gnt = 1;
    #1;
    cyc();
    mem_gnt = 0;
    #1;

    // Reset mid-RESP, then a stale response after reset.
    i_rd_en = 1; i_rd_addr = 32'h1C00_00C0;
    #1;
    cyc();
    i_rd_en = 0;
    mem_gnt = 1;
    #1;
    cyc();
    mem_gnt = 0; reset = 1;
    cyc();
    reset = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_0001;
    #1;
    check("r_i_valid", i_rd_valid, 0);
    check("r_d_valid", d_rd_valid, 0);
    check("r_mem_req", mem_req, 0);
    check("r_mem_addr", mem_addr, 0);
    check("r_i_data", i_rd_data, 0);
    cyc();
    mem_rvalid = 0;
    #1;
    check("r_still_idle", mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one external single-port memory channel between the instruction port (read-only) and the data port (read/write) of the core.
- Sits between the core's iram/dram sram-style ports and the SoC memory/bridge.
- Keeps one transaction outstanding at a time.
- Data port has priority, with an anti-starvation counter that guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits; range 1..15

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- i_rd_en  in  1  fetch read request (level; held until i_rd_ready)
- i_rd_addr  in  ADDR_W  fetch address
- i_rd_ready  out  1  fetch request accepted this cycle
- i_rd_valid  out  1  fetch data valid pulse
- i_rd_data  out  DATA_W  fetch data
- i_cancel_rd  in  1  drop the pending/outstanding fetch response
- d_rd_en  in  1  load request
- d_rd_addr  in  ADDR_W  load address
- d_rd_ready  out  1  load accepted
- d_rd_valid  out  1  load data valid pulse
- d_rd_data  out  DATA_W  load data
- d_wr_en  in  1  store request
- d_wr_addr  in  ADDR_W  store address
- d_wr_data  in  DATA_W  store data
- d_wr_mask  in  4  byte enables
- d_wr_busy  out  1  store not yet accepted; requester holds its signals
- mem_req  out  1  downstream request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream write data
- mem_wmask  out  4  downstream byte enables
- mem_gnt  in  1  downstream accepts the request this cycle
- mem_rvalid  in  1  read response valid
- mem_rdata  in  DATA_W  read response data

Behaviour:
- FSM states: IDLE, REQ, RESP.
- Reset: state=IDLE; streak=0; cancel_flag=0; all outputs 0 except data buses, which are don't-care and driven 0.
- IDLE arbitration, evaluated on the same cycle the requests arrive:
  - Order: d_wr_en > d_rd_en > i_rd_en.
  - Override: if i_rd_en && streak==MAX_D_STREAK, the fetch wins.
- On a win in IDLE:
  - Latch owner, we, addr, wdata and mask.
  - Pulse the matching *_rd_ready for 1 cycle (writes: none).
  - Go to REQ.
- Streak counter:
  - +1 on each data grant while i_rd_en=1, saturating at MAX_D_STREAK.
  - Cleared on a fetch grant, or when i_rd_en=0 in IDLE.
- REQ:
  - mem_req=1 with the latched fields.
  - On mem_gnt: write goes to IDLE; read goes to RESP.
  - Fields stay stable until mem_gnt.
- RESP:
  - On mem_rvalid, route mem_rdata to the owner's rd_data/rd_valid combinationally (0-cycle pass-through), then go to IDLE.
  - Minimum load/fetch latency is accept + 2 cycles when gnt and rvalid each arrive next cycle.
- d_wr_busy = d_wr_en && !(store granted in IDLE this cycle). The store is accepted on the IDLE grant cycle; busy deasserts that cycle.
- Fetch cancel:
  - i_cancel_rd while the owner is fetch in REQ or RESP sets cancel_flag.
  - i_cancel_rd in the cycle of the fetch's i_rd_ready also sets cancel_flag.
  - The response is still consumed from memory, but i_rd_valid is suppressed.
  - cancel_flag clears on return to IDLE.
  - i_cancel_rd with no fetch in flight has no effect.
- A new request is never accepted on the same cycle the previous transaction completes; IDLE always lasts at least 1 cycle.
- mem_rvalid outside RESP is ignored, including stale responses after reset.
- Reset mid-transaction: immediately return to IDLE, dropping the transaction silently; no valid pulse.
- d_rd_en and d_wr_en both high: write granted first; the read waits in IDLE for the next arbitration.

Decomposition:
- Shared package (bus_pkg): owner enum {OWN_I, OWN_D}, state enum {IDLE, REQ, RESP}, constant WMASK_W=4.
- One sub-module, arb_prio_streak: combinational priority plus the streak counter, producing grant_i/grant_d. The FSM and datapath latch stay in the top.

Test Plan:
- Fetch only: i_rd_en addr 0x1C000000; gnt next cycle, rvalid next cycle with 0x02800C00 -> i_rd_ready at t0, i_rd_valid/data 0x02800C00 at t2; d_* outputs stay 0.
- Simultaneous store (addr 0x100, data 0xDEADBEEF, mask 0xF) and load 0x104 -> mem_we=1 transaction first, d_wr_busy low at accept; load issued afterwards; d_rd_valid carries the load data.
- Starvation: i_rd_en held high with back-to-back d_rd_en, MAX_D_STREAK=4 -> exactly 4 data grants, then the fetch is granted; streak returns to 0.
- Cancel: fetch accepted, i_cancel_rd asserted during RESP, rvalid arrives -> no i_rd_valid; FSM in IDLE the next cycle; a following fetch returns normally.
- Stall: mem_gnt held low 5 cycles during a store -> mem_req/addr/wdata/mask stable all 5 cycles; back to IDLE on the gnt cycle.
- Reset mid-RESP, then stale mem_rvalid after reset -> no rd_valid pulse on either port; outputs at reset values.
